button_debouncer: RTL



---
 rtl/button_debouncer.sv | 135 +++++++++++++
 1 files changed

// File: rtl/button_debouncer.sv
// Pushbutton conditioner: two-flop synchronizer, stability filter, and a
// press/hold FSM producing event pulses, a long-press level and a press count.
module button_debouncer #(
    parameter int STABLE_CYCLES = 50000,
    parameter int FILT_W        = 16,
    parameter int LONG_CYCLES   = 50000000,
    parameter int LONG_W        = 26
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_raw,
    output logic       btn_clean,
    output logic       press_pulse,
    output logic       release_pulse,
    output logic       long_press,
    output logic [7:0] press_count
);

    typedef enum logic [1:0] {
        RELEASED = 2'd0,
        PRESSED  = 2'd1,
        LONG     = 2'd2
    } state_e;

    localparam logic [FILT_W-1:0] FILT_MAX = FILT_W'(STABLE_CYCLES - 1);
    localparam logic [LONG_W-1:0] HOLD_MAX = LONG_W'(LONG_CYCLES - 1);

    // sync_q[0] is the metastability catcher, sync_q[1] the usable sample
    logic [1:0]        sync_q;
    logic              s2;
    logic [FILT_W-1:0] filt_q, filt_d;
    logic              clean_q, clean_d;
    logic              fall, rise;

    state_e            state_q;
    logic [LONG_W-1:0] hold_q;
    logic              press_q, release_q, long_q;
    logic [7:0]        count_q;

    assign s2 = sync_q[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], btn_raw};
        end
    end

    // Any sample matching the current level restarts the stability count.
    always_comb begin
        filt_d  = filt_q;
        clean_d = clean_q;
        if (s2 == clean_q) begin
            filt_d = '0;
        end else if (filt_q == FILT_MAX) begin
            clean_d = s2;
            filt_d  = '0;
        end else begin
            filt_d = filt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            filt_q  <= '0;
            clean_q <= 1'b1;
        end else begin
            filt_q  <= filt_d;
            clean_q <= clean_d;
        end
    end

    // Edges are taken from the filter's next state so the pulses register on
    // the same edge that btn_clean changes.
    assign fall = clean_q & ~clean_d;
    assign rise = ~clean_q & clean_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= RELEASED;
            hold_q    <= '0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            long_q    <= 1'b0;
            count_q   <= '0;
        end else begin
            press_q   <= 1'b0;
            release_q <= 1'b0;
            case (state_q)
                RELEASED: begin
                    if (fall) begin
                        state_q <= PRESSED;
                        press_q <= 1'b1;
                        count_q <= count_q + 8'd1;
                        hold_q  <= '0;
                    end
                end
                PRESSED: begin
                    if (rise) begin
                        state_q   <= RELEASED;
                        release_q <= 1'b1;
                        long_q    <= 1'b0;
                        hold_q    <= '0;
                    end else if (hold_q == HOLD_MAX) begin
                        state_q <= LONG;
                        long_q  <= 1'b1;
                    end else begin
                        hold_q <= hold_q + 1'b1;
                    end
                end
                LONG: begin
                    if (rise) begin
                        state_q   <= RELEASED;
                        release_q <= 1'b1;
                        long_q    <= 1'b0;
                        hold_q    <= '0;
                    end
                end
                default: begin
                    state_q <= RELEASED;
                    long_q  <= 1'b0;
                    hold_q  <= '0;
                end
            endcase
        end
    end

    assign btn_clean     = clean_q;
    assign press_pulse   = press_q;
    assign release_pulse = release_q;
    assign long_press    = long_q;
    assign press_count   = count_q;

endmodule
